// File: rtl/hazard_sequencer.sv
// Pipeline stall/flush sequencer: arbitrates data-memory wait, taken-branch flush and
// load-use bubbles, enforces a data-memory timeout and counts stalled cycles.
module hazard_sequencer #(
    parameter int unsigned MEM_TIMEOUT = 8,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             CLK,
    input  logic             clear_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [6:0]       ex_op,
    input  logic [4:0]       ex_rd,
    input  logic             branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_bubble,
    output logic             exmem_en,
    output logic             memwb_bubble,
    output logic             mem_fault,
    output logic [CNT_W-1:0] stall_cnt
);

    // wait_cnt only has to reach MEM_TIMEOUT-1
    localparam int unsigned       WaitW    = $clog2(MEM_TIMEOUT);
    localparam logic [WaitW-1:0]  WaitLast = WaitW'(MEM_TIMEOUT - 1);
    localparam logic [6:0]        OpLoad   = 7'b0000011;

    typedef enum logic [1:0] {StRun, StMemWait, StFault} state_e;

    state_e             state_q, state_d;
    logic [WaitW-1:0]   wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

    logic memwait;
    logic loaduse;
    logic freeze;

    assign memwait = dmem_req & ~dmem_ready;
    assign loaduse = (ex_op == OpLoad) && (ex_rd != 5'd0) &&
                     ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

    // Next-state and freeze decision; a ready arriving on the last wait cycle beats the fault.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        freeze     = 1'b0;
        case (state_q)
            StRun: begin
                if (memwait) begin
                    freeze     = 1'b1;
                    state_d    = StMemWait;
                    wait_cnt_d = WaitW'(1);
                end
            end
            StMemWait: begin
                if (!dmem_ready) begin
                    freeze = 1'b1;
                    if (wait_cnt_q == WaitLast) begin
                        state_d = StFault;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                end else begin
                    state_d    = StRun;
                    wait_cnt_d = '0;
                end
            end
            StFault: begin
                freeze = 1'b1;
            end
            default: begin
                state_d    = StRun;
                wait_cnt_d = '0;
            end
        endcase
    end

    // Pipeline controls: freeze first, then branch flush, then load-use bubble.
    always_comb begin
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        ifid_flush   = 1'b0;
        idex_en      = 1'b1;
        idex_bubble  = 1'b0;
        exmem_en     = 1'b1;
        memwb_bubble = 1'b0;
        mem_fault    = (state_q == StFault);
        if (freeze) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            exmem_en     = 1'b0;
            memwb_bubble = 1'b1;
        end else if (branch_taken) begin
            // ID holds a wrong-path instruction, so squash it rather than stall on it
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (loaduse) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    // Saturating count of cycles where the PC did not advance.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!pc_en && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // State and counter registers.
    always_ff @(posedge CLK or negedge clear_n) begin
        if (!clear_n) begin
            state_q     <= StRun;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule
